// File: rtl/adc7478_sampler.sv
// adc7478_sampler: periodic sample scheduler for the adc7478 serial ADC reader.
// Raises the reader's level-sensitive start once per programmable period, waits
// for its sticky eoc, then drops start for one cycle so the reader resets.
// Every 2**LOG2_AVG kept conversions it presents the truncated mean on a
// valid/ready stream. Missed ticks, dropped means and eoc timeouts are flagged.
// Optional feature macro: ADC_PEAK_HOLD_EN adds peak_data, the largest kept
// sample since enable rose or since the last accepted average.
module adc7478_sampler #(
    parameter int PERIOD_W = 16,
    parameter int LOG2_AVG = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                adc_start,
    input  logic                adc_eoc,
    input  logic [7:0]          adc_data,
    output logic [7:0]          avg_data,
    output logic                avg_valid,
    input  logic                avg_ready,
    output logic                overrun,
    output logic                timeout_err,
    output logic                busy
`ifdef ADC_PEAK_HOLD_EN
    ,
    output logic [7:0]          peak_data
`endif
);

    localparam int ACC_W = 8 + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    // adc_start stays high for exactly TIMEOUT cycles before an abort.
    localparam logic [7:0]       WD_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CONVERT,
        S_RELEASE,
        S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [7:0]          wd_q, wd_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                emit_pend_q, emit_pend_d;
    logic                adc_start_q, adc_start_d;
    logic [7:0]          avg_data_q, avg_data_d;
    logic                avg_valid_q, avg_valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;

    logic tick;
    logic accept;
    logic sample_kept;
    logic cnt_last;

    // Truncated mean of the accumulated block.
    function automatic logic [7:0] mean_trunc(input logic [ACC_W-1:0] a);
        return 8'(a >> LOG2_AVG);
    endfunction

    // Unsigned maximum of two samples.
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    assign tick        = (state_q != S_IDLE) && (timer_q == period_q);
    assign accept      = avg_valid_q && avg_ready;
    assign sample_kept = enable && (state_q == S_CONVERT) && adc_eoc;
    // With LOG2_AVG = 0 every kept sample closes a block (pass-through).
    assign cnt_last    = (LOG2_AVG == 0) || (cnt_q == CNT_LAST);

    // Next-state logic for the scheduler FSM, tick timer and averaging datapath.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        timer_d       = (state_q == S_IDLE) ? '0 : (tick ? '0 : timer_q + 1'b1);
        wd_d          = wd_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        emit_pend_d   = emit_pend_q;
        adc_start_d   = adc_start_q;
        avg_data_d    = avg_data_q;
        avg_valid_d   = avg_valid_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        if (!enable) begin
            // Disabled: behave like reset, but keep the last presented mean.
            state_d       = S_IDLE;
            timer_d       = '0;
            wd_d          = '0;
            acc_d         = '0;
            cnt_d         = '0;
            emit_pend_d   = 1'b0;
            adc_start_d   = 1'b0;
            avg_valid_d   = 1'b0;
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            if (accept) begin
                avg_valid_d = 1'b0;
            end
            // A tick outside WAIT is lost, never queued.
            if (tick && (state_q == S_CONVERT || state_q == S_RELEASE || state_q == S_EMIT)) begin
                overrun_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    period_d = period;
                    timer_d  = '0;
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    if (tick) begin
                        adc_start_d = 1'b1;
                        wd_d        = '0;
                        state_d     = S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    wd_d = wd_q + 1'b1;
                    // eoc takes priority over a coincident watchdog expiry.
                    if (adc_eoc) begin
                        acc_d       = acc_q + ACC_W'(adc_data);
                        cnt_d       = cnt_q + 1'b1;
                        emit_pend_d = cnt_last;
                        adc_start_d = 1'b0;
                        state_d     = S_RELEASE;
                    end else if (wd_q == WD_LAST) begin
                        adc_start_d   = 1'b0;
                        timeout_err_d = 1'b1;
                        emit_pend_d   = 1'b0;
                        state_d       = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state_d = emit_pend_q ? S_EMIT : S_WAIT;
                end
                S_EMIT: begin
                    emit_pend_d = 1'b0;
                    acc_d       = '0;
                    // An unconsumed mean is kept; the new one is dropped.
                    if (avg_valid_q && !avg_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        avg_data_d  = mean_trunc(acc_q);
                        avg_valid_d = 1'b1;
                    end
                    state_d = S_WAIT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            period_q      <= '0;
            timer_q       <= '0;
            wd_q          <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            emit_pend_q   <= 1'b0;
            adc_start_q   <= 1'b0;
            avg_data_q    <= '0;
            avg_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            timer_q       <= timer_d;
            wd_q          <= wd_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            emit_pend_q   <= emit_pend_d;
            adc_start_q   <= adc_start_d;
            avg_data_q    <= avg_data_d;
            avg_valid_q   <= avg_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign adc_start   = adc_start_q;
    assign avg_data    = avg_data_q;
    assign avg_valid   = avg_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q == S_CONVERT) || (state_q == S_RELEASE);

`ifdef ADC_PEAK_HOLD_EN
    logic [7:0] peak_q, peak_d;

    // Peak tracker: restarts from the current sample when an average is taken.
    always_comb begin
        peak_d = peak_q;
        if (!enable) begin
            peak_d = '0;
        end else if (accept) begin
            peak_d = sample_kept ? adc_data : 8'h00;
        end else if (sample_kept) begin
            peak_d = max8(peak_q, adc_data);
        end
    end

    // Peak register with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_data = peak_q;
`endif

endmodule
